ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard scanner. It adds:
- a glitch filter on the PS/2 clock;
- an inter-edge timeout watchdog;
- full frame checking with sticky error flags;
- optional E0/F0 prefix folding;
- a show-ahead receive FIFO, so the CPU-side bus interface can drain scan codes at leisure.

It sits between the PS/2 pins and the keyboard peripheral register block.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_rx_fifo_if.sv | 17 +
 rtl/ps2_sync_fifo.sv | 45 ++++
 rtl/ps2_rx_fifo.sv | 126 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, frame bit positions and receiver state encoding.
package ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int PS2_BIT_START  = 0;
  localparam int PS2_BIT_PARITY = 9;
  localparam int PS2_BIT_STOP   = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} ps2_state_e;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// CPU-side bus of the PS/2 receiver: FIFO drain, status and sticky error flags.
interface ps2_rx_fifo_if #(parameter int FIFO_DEPTH = 16) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_i;
  logic          clr_err_i;
  logic [9:0]    data_o;
  logic          valid_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          frame_err_o;

  modport master (output rd_i, clr_err_i,
                  input  data_o, valid_o, count_o, overflow_o, frame_err_o);
  modport slave  (input  rd_i, clr_err_i,
                  output data_o, valid_o, count_o, overflow_o, frame_err_o);
endinterface

// File: rtl/ps2_sync_fifo.sv
// Generic show-ahead FIFO; rdata is the head entry (zero while empty).
module ps2_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered clock, frame checker with timeout,
// optional E0/F0 prefix folding, show-ahead receive FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN    = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_CYC   = 50000,
  parameter int DECODE_PREFIX = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           kb_clk_i,
  input  logic           kb_dat_i,
  ps2_rx_fifo_if.slave   bus
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    kc_s, kd_s;
  logic [FW-1:0] fcnt;
  logic          filt, filt_d, fall;
  ps2_state_e    state, nxt;
  logic [3:0]    idx;
  logic [9:0]    sh;
  logic [TW-1:0] tcnt;
  logic          ext, brk, ovf, ferr;
  logic          timeout, good, commit, bad, is_ext, is_brk, wr, full, empty;
  logic [9:0]    wdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      kc_s   <= 2'b11;
      kd_s   <= 2'b11;
      fcnt   <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      kc_s   <= {kc_s[0], kb_clk_i};
      kd_s   <= {kd_s[0], kb_dat_i};
      filt_d <= filt;
      if (kc_s[1] != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= kc_s[1];
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall    = filt_d && !filt;
  assign timeout = (state == ST_SHIFT) && !fall && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (fall && !kd_s[1]) nxt = ST_SHIFT;
      ST_SHIFT: if (fall && idx == 4'(PS2_BIT_STOP)) nxt = ST_CHECK;
                else if (timeout)                    nxt = ST_IDLE;
      ST_CHECK: nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // sh holds bits 1..10 once the stop bit has shifted in: data in [7:0].
  assign good   = sh[PS2_BIT_STOP-1] && odd_parity_ok(sh[7:0], sh[PS2_BIT_PARITY-1]);
  assign commit = (state == ST_CHECK) && good;
  assign bad    = (state == ST_CHECK) && !good;
  assign is_ext = (DECODE_PREFIX != 0) && (sh[7:0] == PS2_PREFIX_EXT);
  assign is_brk = (DECODE_PREFIX != 0) && (sh[7:0] == PS2_PREFIX_BRK);
  assign wr     = commit && !is_ext && !is_brk;
  assign wdata  = (DECODE_PREFIX != 0) ? {ext, brk, sh[7:0]} : {2'b00, sh[7:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx  <= '0;
      sh   <= '0;
      tcnt <= '0;
      ext  <= 1'b0;
      brk  <= 1'b0;
      ovf  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (state == ST_IDLE && fall && !kd_s[1]) idx <= 4'(PS2_BIT_START + 1);
      else if (state == ST_SHIFT && fall)       idx <= idx + 1'b1;
      if (state == ST_SHIFT && fall) sh <= {kd_s[1], sh[9:1]};
      if (state != ST_SHIFT || fall) tcnt <= '0;
      else                           tcnt <= tcnt + 1'b1;
      if (commit && is_ext)      ext <= 1'b1;
      else if (commit && is_brk) brk <= 1'b1;
      else if (wr) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
      if (wr && full && !bus.rd_i) ovf <= 1'b1;
      else if (bus.clr_err_i)      ovf <= 1'b0;
      if (bad || timeout)          ferr <= 1'b1;
      else if (bus.clr_err_i)      ferr <= 1'b0;
    end
  end

  ps2_sync_fifo #(.W(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .wr    (wr),
    .wdata (wdata),
    .rd    (bus.rd_i),
    .rdata (bus.data_o),
    .full  (full),
    .empty (empty),
    .count (bus.count_o)
  );

  assign bus.valid_o     = !empty;
  assign bus.overflow_o  = ovf;
  assign bus.frame_err_o = ferr;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: prefix-folding and raw instances share the PS/2 pins,
// expected FIFO entries come from a queue-based model of both.
module tb_ps2_rx_fifo;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic kb_clk = 1'b1;
  logic kb_dat = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic       m_ext = 1'b0, m_brk = 1'b0;

  ps2_rx_fifo_if #(.FIFO_DEPTH(16)) bus0 ();
  ps2_rx_fifo_if #(.FIFO_DEPTH(16)) bus1 ();

  ps2_rx_fifo #(.FILTER_LEN(4), .FIFO_DEPTH(16), .TIMEOUT_CYC(200), .DECODE_PREFIX(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat), .bus(bus0));
  ps2_rx_fifo #(.FILTER_LEN(4), .FIFO_DEPTH(16), .TIMEOUT_CYC(200), .DECODE_PREFIX(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .kb_clk_i(kb_clk), .kb_dat_i(kb_dat), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_commit(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (q0.size() < 16) q0.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    if (q1.size() < 16) q1.push_back({2'b00, b});
  endtask

  task automatic pop0(input string tag);
    logic [9:0] e;
    e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
    chk({tag, "_valid"}, 32'(bus0.valid_o), 32'd1);
    chk({tag, "_data"}, 32'(bus0.data_o), 32'(e));
    bus0.rd_i = 1'b1;
    @(negedge clk);
    bus0.rd_i = 1'b0;
  endtask

  task automatic pop1(input string tag);
    logic [9:0] e;
    e = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    chk({tag, "_valid"}, 32'(bus1.valid_o), 32'd1);
    chk({tag, "_data"}, 32'(bus1.data_o), 32'(e));
    bus1.rd_i = 1'b1;
    @(negedge clk);
    bus1.rd_i = 1'b0;
  endtask

  task automatic clr_err();
    bus0.clr_err_i = 1'b1;
    bus1.clr_err_i = 1'b1;
    @(negedge clk);
    bus0.clr_err_i = 1'b0;
    bus1.clr_err_i = 1'b0;
  endtask

  task automatic half_phase(input logic lvl, input bit glitch);
    if (glitch) begin
      repeat (8) @(negedge clk);
      kb_clk = ~lvl;
      repeat (2) @(negedge clk);
      kb_clk = lvl;
      repeat (HALF - 10) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Sends nbits of a frame; on a full frame, optionally checks commit latency
  // and/or pops dut0 in the commit cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stopv,
                            input int nbits, input bit glitch, input bit rdc, input bit latchk);
    logic [10:0] f;
    logic [9:0]  e;
    f = {stopv, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kb_dat = f[i];
      half_phase(1'b1, glitch);
      kb_clk = 1'b0;
      if (i == 10) begin
        repeat (7) @(posedge clk);
        @(negedge clk);
        if (latchk) chk("lat_check_cycle_valid", 32'(bus0.valid_o), 32'd0);
        if (rdc) begin
          e = (q0.size() > 0) ? q0.pop_front() : 10'h3FF;
          chk("rdc_head", 32'(bus0.data_o), 32'(e));
          bus0.rd_i = 1'b1;
        end
        if (stopv && !bad_par) model_commit(b);
        @(negedge clk);
        bus0.rd_i = 1'b0;
        if (latchk) begin
          chk("lat_valid", 32'(bus0.valid_o), 32'd1);
          chk("lat_data", 32'(bus0.data_o), 32'(q0[0]));
        end
        repeat (HALF - 9) @(negedge clk);
      end else begin
        half_phase(1'b0, glitch);
      end
      kb_clk = 1'b1;
    end
    kb_dat = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    bus0.rd_i = 1'b0; bus0.clr_err_i = 1'b0;
    bus1.rd_i = 1'b0; bus1.clr_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus0.valid_o), 32'd0);
    chk("rst_count", 32'(bus0.count_o), 32'd0);
    chk("rst_data", 32'(bus0.data_o), 32'd0);
    chk("rst_ferr", 32'(bus0.frame_err_o), 32'd0);
    chk("rst_ovf", 32'(bus0.overflow_o), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // single key with latency check
    send_frame(8'h1C, 0, 1'b1, 11, 0, 0, 1);
    chk("k1c_q", 32'(q0[0]), 32'h01C);
    pop0("k1c");
    pop1("k1c_raw");
    chk("k1c_after_valid", 32'(bus0.valid_o), 32'd0);
    chk("k1c_after_count", 32'(bus0.count_o), 32'd0);
    bus0.rd_i = 1'b1;
    @(negedge clk);
    bus0.rd_i = 1'b0;
    chk("rd_empty_count", 32'(bus0.count_o), 32'd0);

    // prefix folding vs raw
    send_frame(8'hE0, 0, 1'b1, 11, 0, 0, 0);
    send_frame(8'hF0, 0, 1'b1, 11, 0, 0, 0);
    send_frame(8'h75, 0, 1'b1, 11, 0, 0, 0);
    chk("pfx_count0", 32'(bus0.count_o), 32'd1);
    chk("pfx_count1", 32'(bus1.count_o), 32'd3);
    chk("pfx_model", 32'(q0[0]), 32'h375);
    pop0("pfx0");
    pop1("raw_e0");
    pop1("raw_f0");
    pop1("raw_75");

    // frame errors
    send_frame(8'h1C, 1, 1'b1, 11, 0, 0, 0);
    chk("par_ferr", 32'(bus0.frame_err_o), 32'd1);
    chk("par_count", 32'(bus0.count_o), 32'd0);
    clr_err();
    chk("par_clr", 32'(bus0.frame_err_o), 32'd0);
    send_frame(8'h1C, 0, 1'b0, 11, 0, 0, 0);
    chk("stop_ferr", 32'(bus0.frame_err_o), 32'd1);
    chk("stop_count", 32'(bus0.count_o), 32'd0);
    clr_err();
    chk("stop_clr", 32'(bus0.frame_err_o), 32'd0);

    // glitches on kb_clk are filtered
    send_frame(8'hA5, 0, 1'b1, 11, 1, 0, 0);
    chk("glitch_count", 32'(bus0.count_o), 32'd1);
    chk("glitch_ferr", 32'(bus0.frame_err_o), 32'd0);
    pop0("glitch");

    // timeout after 5 bits, then recovery
    send_frame(8'h55, 0, 1'b1, 5, 0, 0, 0);
    repeat (300) @(negedge clk);
    chk("to_ferr", 32'(bus0.frame_err_o), 32'd1);
    chk("to_count", 32'(bus0.count_o), 32'd0);
    clr_err();
    send_frame(8'h2A, 0, 1'b1, 11, 0, 0, 0);
    chk("to_next_ferr", 32'(bus0.frame_err_o), 32'd0);
    pop0("to_next");

    // overflow and full-FIFO simultaneous read/write
    q1.delete();
    for (int k = 1; k <= 17; k++) send_frame(8'(k), 0, 1'b1, 11, 0, 0, 0);
    chk("ovf_count", 32'(bus0.count_o), 32'd16);
    chk("ovf_flag", 32'(bus0.overflow_o), 32'd1);
    clr_err();
    chk("ovf_clr", 32'(bus0.overflow_o), 32'd0);
    send_frame(8'h12, 0, 1'b1, 11, 0, 1, 0);
    chk("full_rw_count", 32'(bus0.count_o), 32'd16);
    chk("full_rw_ovf", 32'(bus0.overflow_o), 32'd0);
    for (int k = 0; k < 16; k++) pop0("drain");
    chk("drain_valid", 32'(bus0.valid_o), 32'd0);

    // async reset mid-frame
    send_frame(8'h33, 0, 1'b1, 11, 0, 0, 0);
    send_frame(8'h33, 1, 1'b1, 11, 0, 0, 0);
    send_frame(8'h66, 0, 1'b1, 4, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus0.valid_o), 32'd0);
    chk("mrst_count", 32'(bus0.count_o), 32'd0);
    chk("mrst_data", 32'(bus0.data_o), 32'd0);
    chk("mrst_ferr", 32'(bus0.frame_err_o), 32'd0);
    chk("mrst_ovf", 32'(bus0.overflow_o), 32'd0);
    q0.delete(); q1.delete();
    m_ext = 1'b0; m_brk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h4D, 0, 1'b1, 11, 0, 0, 0);
    chk("post_rst_count", 32'(bus0.count_o), 32'd1);
    pop0("post_rst");
    chk("post_rst_ferr", 32'(bus0.frame_err_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
